// File: rtl/weight_chain_loader_pkg.sv
// Shared definitions for the weight chain loader: FSM state encoding,
// pipeline timing constants and the packed-weight field layout.
package wload_pkg;

    // Loader FSM states. The top module mirrors these as plain logic constants.
    typedef enum logic [2:0] {
        WL_IDLE      = 3'd0,
        WL_READ      = 3'd1,
        WL_DRAIN     = 3'd2,
        WL_WAIT_SWAP = 3'd3,
        WL_SET       = 3'd4
    } wl_state_e;

    // Weight buffer returns data one cycle after the read enable.
    localparam int WL_RD_LATENCY = 1;

    // Read enable to prepare_weight: one RAM cycle plus one output register.
    localparam int WL_PIPE_DELAY = 2;

    // Cycles spent in DRAIN while the last words travel through the pipeline.
    localparam int WL_DRAIN_CYCLES = 2;

    // Two signed 8-bit weights are packed into each 16-bit buffer word.
    localparam int WL_WEIGHT_WIDTH = 8;
    localparam int W0_LSB          = 0;
    localparam int W1_LSB          = 8;

endpackage

// File: rtl/weight_chain_loader_if.sv
// Bus between the weight chain loader and its surroundings: the tile
// request from the scheduler, the weight-buffer read port and the column
// weight-chain drive signals.
//
// Handshake rules:
//   - i_start is a one-cycle request; it is accepted only while o_busy is low
//     and is silently dropped otherwise (no queueing). i_base_addr is sampled
//     on the accepting edge.
//   - o_wbuf_rd_en/o_wbuf_rd_addr form a read command with no back-pressure;
//     i_wbuf_rd_data must be valid exactly one cycle after o_wbuf_rd_en.
//   - o_prepare_weight qualifies o_load_weight_data_0/1 each cycle it is high;
//     the data lines hold their last value otherwise.
//   - o_set_weight/o_done pulse together for one cycle, only after
//     i_swap_allow has been sampled high with the tile fully shifted in.
interface weight_chain_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic              i_swap_allow;
    logic              o_busy;
    logic              o_done;
    logic              o_wbuf_rd_en;
    logic [ADDR_W-1:0] o_wbuf_rd_addr;
    logic [DATA_W-1:0] i_wbuf_rd_data;
    logic              o_prepare_weight;
    logic              o_set_weight;
    logic [7:0]        o_load_weight_data_0;
    logic [7:0]        o_load_weight_data_1;

    // Loader side.
    modport master (
        input  i_start,
        input  i_base_addr,
        input  i_swap_allow,
        input  i_wbuf_rd_data,
        output o_busy,
        output o_done,
        output o_wbuf_rd_en,
        output o_wbuf_rd_addr,
        output o_prepare_weight,
        output o_set_weight,
        output o_load_weight_data_0,
        output o_load_weight_data_1
    );

    // Scheduler / buffer / column side.
    modport slave (
        output i_start,
        output i_base_addr,
        output i_swap_allow,
        output i_wbuf_rd_data,
        input  o_busy,
        input  o_done,
        input  o_wbuf_rd_en,
        input  o_wbuf_rd_addr,
        input  o_prepare_weight,
        input  o_set_weight,
        input  o_load_weight_data_0,
        input  o_load_weight_data_1
    );

endinterface

// File: rtl/weight_chain_loader.sv
// Weight chain loader: reads one tile of ARRAY_ROWS packed weight words
// from the weight buffer, shifts them into a MAC column's weight chain with
// contiguous prepare_weight cycles (farthest row first), then issues a
// single set_weight once the compute side allows the swap.
module weight_chain_loader
    import wload_pkg::*;
#(
    parameter int ARRAY_ROWS      = 16,
    parameter int WBUF_ADDR_WIDTH = 10,
    parameter int WBUF_DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    weight_chain_loader_if.master bus,
    output logic [2:0]            o_dbg_state
);

    // ARRAY_ROWS must be at least 1; the counter also reuses its range for
    // the two DRAIN cycles, which $clog2(ARRAY_ROWS+1) >= 1 bit covers.
    localparam int CNT_W = $clog2(ARRAY_ROWS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ARRAY_ROWS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(WL_DRAIN_CYCLES - 1);

    // Offset of the farthest row's word from the tile base.
    localparam logic [WBUF_ADDR_WIDTH-1:0] ADDR_TOP = WBUF_ADDR_WIDTH'(ARRAY_ROWS - 1);

    localparam logic [2:0] S_IDLE      = WL_IDLE;
    localparam logic [2:0] S_READ      = WL_READ;
    localparam logic [2:0] S_DRAIN     = WL_DRAIN;
    localparam logic [2:0] S_WAIT_SWAP = WL_WAIT_SWAP;
    localparam logic [2:0] S_SET       = WL_SET;

    logic [2:0]                 state_q;
    logic [2:0]                 state_d;
    logic [CNT_W-1:0]           cnt_q;
    logic [CNT_W-1:0]           cnt_d;
    logic [WBUF_ADDR_WIDTH-1:0] base_q;

    logic                       busy_q;
    logic                       done_q;
    logic                       set_q;
    logic                       rd_en_q;
    logic [WBUF_ADDR_WIDTH-1:0] rd_addr_q;
    logic [WL_PIPE_DELAY-1:0]   pipe_q;
    logic [7:0]                 w0_q;
    logic [7:0]                 w1_q;

    logic [WBUF_DATA_WIDTH-1:0] rd_data;
    logic                       data_valid;

    assign rd_data    = bus.i_wbuf_rd_data;
    // pipe_q[0] is rd_en delayed by the RAM latency: buffer data is valid now.
    assign data_valid = pipe_q[WL_RD_LATENCY-1];

    // Next-state and counter logic. cnt indexes the read in READ and the
    // drain cycle in DRAIN; it is cleared on every state change that uses it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end
            end
            S_READ: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_WAIT_SWAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT_SWAP: begin
                if (bus.i_swap_allow) begin
                    state_d = S_SET;
                end
            end
            S_SET: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, counter and the base address latched on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && bus.i_start) begin
                base_q <= bus.i_base_addr;
            end
        end
    end

    // Registered control outputs. Busy/set/done follow the next state so
    // set_weight lines up with the SET state; the read port follows the
    // current state, one cycle behind it, with descending addresses that
    // wrap modulo the buffer size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            set_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_SET);
            set_q   <= (state_d == S_SET);
            rd_en_q <= (state_q == S_READ);
            if (state_q == S_READ) begin
                rd_addr_q <= base_q + ADDR_TOP - WBUF_ADDR_WIDTH'(cnt_q);
            end
        end
    end

    // Delay line from the read enable to prepare_weight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[WL_PIPE_DELAY-2:0], rd_en_q};
        end
    end

    // Weight output register: captures the unpacked word in the same edge
    // that raises prepare_weight, and holds it while prepare is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0_q <= '0;
            w1_q <= '0;
        end else if (data_valid) begin
            w0_q <= rd_data[W0_LSB +: WL_WEIGHT_WIDTH];
            w1_q <= rd_data[W1_LSB +: WL_WEIGHT_WIDTH];
        end
    end

    assign bus.o_busy               = busy_q;
    assign bus.o_done               = done_q;
    assign bus.o_set_weight         = set_q;
    assign bus.o_wbuf_rd_en         = rd_en_q;
    assign bus.o_wbuf_rd_addr       = rd_addr_q;
    assign bus.o_prepare_weight     = pipe_q[WL_PIPE_DELAY-1];
    assign bus.o_load_weight_data_0 = w0_q;
    assign bus.o_load_weight_data_1 = w1_q;
    assign o_dbg_state              = state_q;

endmodule

// File: tb/tb_weight_chain_loader.sv
// Bench for weight_chain_loader: a 4-row instance exercised with a table of
// tiles, hand sequences and randomized tiles, plus a 1-row instance.
module tb_weight_chain_loader;

    localparam int R4 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] dbg4;
    logic [2:0] dbg1;

    int n_tests = 0;
    int n_fail  = 0;

    weight_chain_loader_if #(.ADDR_W(10), .DATA_W(16)) bus4 ();
    weight_chain_loader_if #(.ADDR_W(10), .DATA_W(16)) bus1 ();

    weight_chain_loader #(.ARRAY_ROWS(R4), .WBUF_ADDR_WIDTH(10), .WBUF_DATA_WIDTH(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.master), .o_dbg_state(dbg4)
    );

    weight_chain_loader #(.ARRAY_ROWS(1), .WBUF_ADDR_WIDTH(10), .WBUF_DATA_WIDTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master), .o_dbg_state(dbg1)
    );

    // Clock
    always #5 clk = ~clk;

    // Buffer contents: word at a is {a[7:0]+0x80, a[7:0]}
    function automatic logic [15:0] mem_word(input logic [9:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return {lo + 8'h80, lo};
    endfunction

    // 1-cycle-latency RAM models
    always @(posedge clk) if (bus4.o_wbuf_rd_en) bus4.i_wbuf_rd_data <= mem_word(bus4.o_wbuf_rd_addr);
    always @(posedge clk) if (bus1.o_wbuf_rd_en) bus1.i_wbuf_rd_data <= mem_word(bus1.o_wbuf_rd_addr);

    // Behavioural weight chain of the 4-row column: row 0 nearest the loader
    logic [15:0] chain4 [R4];
    always @(posedge clk) begin
        if (bus4.o_prepare_weight) begin
            chain4[0] <= {bus4.o_load_weight_data_1, bus4.o_load_weight_data_0};
            for (int i = 1; i < R4; i++) chain4[i] <= chain4[i-1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle4(input string tag);
        check({tag, "_busy"},    32'(bus4.o_busy), 0);
        check({tag, "_done"},    32'(bus4.o_done), 0);
        check({tag, "_set"},     32'(bus4.o_set_weight), 0);
        check({tag, "_rd_en"},   32'(bus4.o_wbuf_rd_en), 0);
        check({tag, "_rd_addr"}, 32'(bus4.o_wbuf_rd_addr), 0);
        check({tag, "_prep"},    32'(bus4.o_prepare_weight), 0);
        check({tag, "_w0"},      32'(bus4.o_load_weight_data_0), 0);
        check({tag, "_w1"},      32'(bus4.o_load_weight_data_1), 0);
        check({tag, "_state"},   32'(dbg4), 0);
    endtask

    // One tile on the 4-row DUT. Cycle k is the k-th cycle after the accepting
    // edge. swap_allow is sampled low at the first `gap` edges where a swap
    // could happen. inj_k >= 0 drives a second start (base 0x100) in cycle k.
    task automatic run_tile(input logic [9:0] base, input int gap, input int inj_k,
                            input logic [9:0] exp_first, input logic [9:0] exp_last,
                            input int exp_set_k);
        logic [9:0]  obs_addr[$];
        logic [15:0] snap [R4];
        logic [9:0]  exp_a;
        int prep_n, prep_first, prep_last, set_n, set_k, done_bad, busy_bad, limit;
        prep_n = 0; prep_first = -1; prep_last = -1;
        set_n = 0; set_k = -1; done_bad = 0; busy_bad = 0;
        limit = R4 + 3 + gap + 16;
        for (int r = 0; r < R4; r++) snap[r] = '0;
        @(negedge clk);
        bus4.i_start = 1'b1;
        bus4.i_base_addr = base;
        bus4.i_swap_allow = (gap == 0);
        @(posedge clk);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (bus4.o_wbuf_rd_en) obs_addr.push_back(bus4.o_wbuf_rd_addr);
            if (bus4.o_prepare_weight) begin
                if (prep_n == 0) prep_first = k;
                prep_last = k;
                prep_n++;
            end
            if (bus4.o_done !== bus4.o_set_weight) done_bad++;
            if (bus4.o_set_weight) begin
                set_n++;
                if (set_k < 0) begin
                    set_k = k;
                    for (int r = 0; r < R4; r++) snap[r] = chain4[r];
                end
            end
            if (bus4.o_busy !== ((set_k < 0) || (k <= set_k))) busy_bad++;
            bus4.i_start = (k == inj_k);
            bus4.i_base_addr = (k == inj_k) ? 10'h100 : base;
            bus4.i_swap_allow = (gap == 0) || (k + 1 >= R4 + 3 + gap);
            if (set_k >= 0 && k >= set_k + 3) break;
        end
        bus4.i_start = 1'b0;
        bus4.i_swap_allow = 1'b0;

        check("rd_count", obs_addr.size(), R4);
        for (int i = 0; i < R4 && i < obs_addr.size(); i++) begin
            exp_a = base + 10'(R4 - 1 - i);
            check($sformatf("rd_addr[%0d] base=%0h", i, base), 32'(obs_addr[i]), 32'(exp_a));
        end
        if (obs_addr.size() > 0) begin
            check("rd_first", 32'(obs_addr[0]), 32'(exp_first));
            check("rd_last", 32'(obs_addr[obs_addr.size()-1]), 32'(exp_last));
        end
        check("prep_count", prep_n, R4);
        check("prep_first", prep_first, 3);
        check("prep_last", prep_last, R4 + 2);
        check($sformatf("set_cycle base=%0h gap=%0d", base, gap), set_k, exp_set_k);
        check("set_width", set_n, 1);
        check("done_with_set", done_bad, 0);
        check("busy_window", busy_bad, 0);
        for (int r = 0; r < R4; r++)
            check($sformatf("chain_row%0d base=%0h", r, base), 32'(snap[r]), 32'(mem_word(base + 10'(r))));
    endtask

    typedef struct {
        logic [9:0] base;
        int         gap;
        int         inj;
        logic [9:0] exp_first;
        logic [9:0] exp_last;
        int         exp_set_k;
    } tile_vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tile_vec_t vecs[4];
        int b, g, inj, pc, ev_set, ev_rd;
        int rd1_n, prep1_n, prep1_k, set1_k;
        logic [9:0]  addr1;
        logic [15:0] data1;

        vecs[0] = '{10'h010, 0,  -1, 10'h013, 10'h010, 7};   // basic tile
        vecs[1] = '{10'h080, 10, -1, 10'h083, 10'h080, 17};  // swap stall
        vecs[2] = '{10'h3FE, 0,  -1, 10'h001, 10'h3FE, 7};   // address wrap
        vecs[3] = '{10'h040, 0,  1,  10'h043, 10'h040, 7};   // start while busy

        bus4.i_start = 0; bus4.i_base_addr = 0; bus4.i_swap_allow = 0;
        bus1.i_start = 0; bus1.i_base_addr = 0; bus1.i_swap_allow = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle4("reset");
        check("reset1_busy", 32'(bus1.o_busy), 0);
        check("reset1_prep", 32'(bus1.o_prepare_weight), 0);
        check("reset1_state", 32'(dbg1), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven tiles
        for (int v = 0; v < 4; v++)
            run_tile(vecs[v].base, vecs[v].gap, vecs[v].inj,
                     vecs[v].exp_first, vecs[v].exp_last, vecs[v].exp_set_k);

        // Reset during the 3rd prepare cycle
        @(negedge clk);
        bus4.i_start = 1'b1; bus4.i_base_addr = 10'h060; bus4.i_swap_allow = 1'b1;
        @(posedge clk);
        pc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus4.i_start = 1'b0;
            if (bus4.o_prepare_weight) pc++;
            if (pc == 3) break;
        end
        check("rst_reached_prep3", pc, 3);
        #2 rst_n = 1'b0;
        #1 check_idle4("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        ev_set = 0; ev_rd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus4.o_set_weight) ev_set++;
            if (bus4.o_wbuf_rd_en) ev_rd++;
        end
        check("abandoned_no_set", ev_set, 0);
        check("abandoned_no_rd", ev_rd, 0);
        bus4.i_swap_allow = 1'b0;
        run_tile(10'h020, 0, -1, 10'h023, 10'h020, 7);

        // Randomized tiles checked against the reference rules
        for (int t = 0; t < 16; t++) begin
            b = $urandom_range(0, 1023);
            g = $urandom_range(0, 4);
            inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, R4 + 2 + g)) : -1;
            run_tile(10'(b), g, inj, 10'(b) + 10'(R4 - 1), 10'(b), R4 + 3 + g);
        end

        // Single-row column
        @(negedge clk);
        bus1.i_start = 1'b1; bus1.i_base_addr = 10'h005; bus1.i_swap_allow = 1'b1;
        @(posedge clk);
        rd1_n = 0; prep1_n = 0; prep1_k = -1; set1_k = -1; addr1 = '0; data1 = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus1.i_start = 1'b0;
            if (bus1.o_wbuf_rd_en) begin rd1_n++; addr1 = bus1.o_wbuf_rd_addr; end
            if (bus1.o_prepare_weight) begin
                prep1_n++;
                prep1_k = k;
                data1 = {bus1.o_load_weight_data_1, bus1.o_load_weight_data_0};
            end
            if (bus1.o_set_weight && set1_k < 0) set1_k = k;
        end
        check("r1_rd_count", rd1_n, 1);
        check("r1_rd_addr", 32'(addr1), 32'h005);
        check("r1_prep_count", prep1_n, 1);
        check("r1_prep_cycle", prep1_k, 3);
        check("r1_set_cycle", set1_k, 4);
        check("r1_data", 32'(data1), 32'h8505);
        check("r1_idle_after", 32'(bus1.o_busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_chain_loader.md
Name: weight_chain_loader

Overview:
- Upstream feeder for one column of mac_unit_nomantissaout instances.
- The column's weight registers form a shift chain: o_load_weight_data_* of row k drives i_load_weight_data_* of row k+1. prepare_weight and set_weight are broadcast to every row of the column.
- This block reads ARRAY_ROWS weight words from the weight buffer and shifts them into the chain with contiguous prepare_weight cycles.
- It then issues a single set_weight pulse, gated by the compute side, so the next weight tile preloads while the current tile computes.

Parameters:
- ARRAY_ROWS, 16: MAC rows in the column, i.e. chain length and words per tile; must be >= 1.
- WBUF_ADDR_WIDTH, 10: weight-buffer address width.
- WBUF_DATA_WIDTH, 16: buffer word width; two packed 8-bit weights; fixed at 16.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle request to load one tile
- i_base_addr  in  WBUF_ADDR_WIDTH  tile base address; sampled with i_start
- i_swap_allow  in  1  compute side permits set_weight (current tile finished)
- o_busy  out  1  high from accepted start through the set_weight cycle
- o_done  out  1  one-cycle pulse, coincident with o_set_weight
- o_wbuf_rd_en  out  1  buffer read enable
- o_wbuf_rd_addr  out  WBUF_ADDR_WIDTH  buffer read address
- i_wbuf_rd_data  in  16  read data, valid exactly 1 cycle after rd_en
- o_prepare_weight  out  1  to column prepare_weight
- o_set_weight  out  1  to column set_weight
- o_load_weight_data_0  out  8  chain input, weight 0 (signed)
- o_load_weight_data_1  out  8  chain input, weight 1 (signed)

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM to IDLE, counters cleared. Reset mid-load abandons the tile; no set_weight is emitted.
- All outputs are registered.
- FSM states: IDLE, READ, DRAIN, WAIT_SWAP, SET.
- IDLE:
  - i_start=1 latches i_base_addr, clears cnt, goes to READ.
  - o_busy=1 from the next cycle.
- READ:
  - Runs ARRAY_ROWS cycles with o_wbuf_rd_en=1.
  - o_wbuf_rd_addr = base + (ARRAY_ROWS-1-cnt), modulo 2^WBUF_ADDR_WIDTH (wraps silently).
  - Addresses descend so the farthest row is loaded first; row 0 (nearest) ends holding word base+0.
  - Goes to DRAIN when cnt = ARRAY_ROWS-1.
- Data path:
  - o_load_weight_data_0 <= i_wbuf_rd_data[7:0]; o_load_weight_data_1 <= i_wbuf_rd_data[15:8].
  - o_prepare_weight is o_wbuf_rd_en delayed exactly 2 cycles (1 RAM + 1 output register).
  - Prepare is therefore contiguous for exactly ARRAY_ROWS cycles.
  - Data lines hold their last value when prepare is low.
- DRAIN: 2 cycles, then WAIT_SWAP.
- WAIT_SWAP:
  - Goes to SET when i_swap_allow=1 is sampled.
  - Earliest SET is therefore the cycle immediately after the last prepare cycle.
- SET:
  - o_set_weight=1 and o_done=1 for exactly one cycle.
  - Next state IDLE; o_busy drops the following cycle.
- i_start while o_busy=1 is ignored, with no queueing.
- i_swap_allow outside WAIT_SWAP has no effect.
- Full 8 bits are passed; the MAC truncates to its mantissa width.
- Start-to-set latency with i_swap_allow held high: ARRAY_ROWS+3 cycles after the start-accept edge.
- ARRAY_ROWS=1: a single read and a single prepare; all rules unchanged.
- Counter width: $clog2(ARRAY_ROWS+1).

Decomposition:
- Shared package wload_pkg holds:
  - the FSM state enum;
  - WL_RD_LATENCY=1 and WL_PIPE_DELAY=2;
  - weight-field slice constants W0_LSB=0 and W1_LSB=8.
- No sub-module. The FSM, counter and 2-stage rd_en→prepare delay line stay flat.
- The bench supplies a 1-cycle-latency RAM model and a behavioural chain of ARRAY_ROWS registers for checking.

Test Plan:
- Basic tile: ARRAY_ROWS=4, base=0x010, mem[a]={a+0x80, a}, swap_allow=1 → reads 0x013,0x012,0x011,0x010; prepare high for 4 contiguous cycles; set/done pulse 1 cycle after last prepare. Chain row0..3 must then hold (0x10,0x90),(0x11,0x91),(0x12,0x92),(0x13,0x93).
- Swap stall: i_swap_allow=0 for 10 cycles after the last prepare → busy held, no set. Raising swap_allow → set/done on the next cycle, exactly one cycle wide.
- Address wrap: WBUF_ADDR_WIDTH=10, base=0x3FE, ARRAY_ROWS=4 → addresses 0x001,0x000,0x3FF,0x3FE.
- Start while busy: second i_start (base=0x100) during READ → ignored. Only the original 4 reads occur, followed by a single done.
- Reset mid-operation: rst_n low during the 3rd prepare cycle → all outputs 0 immediately, no set_weight. A subsequent start (base=0x020) completes a full clean tile.
- ARRAY_ROWS=1, base=0x005 → one read at 0x005; one prepare; set on the next cycle.
